// File: rtl/collision_engine_if.sv
// Bundle between the ball position register, the collision engine and the motion/score logic.
interface collision_engine_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int PW_W    = 6,
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic [X_W-1:0]     ball_x;
  logic [Y_W-1:0]     ball_y;
  logic [Y_W-1:0]     paddle_0;
  logic [Y_W-1:0]     paddle_1;
  logic [PW_W-1:0]    paddlewidth;
  logic               new_game;
  logic               coll_L, coll_R, coll_T, coll_B;
  logic [1:0]         hit_zone;
  logic               point_p1, point_p2;
  logic [SCORE_W-1:0] score_0, score_1;
  logic               ball_reset, serving, game_over;

  modport master (
    output frame_tick, ball_x, ball_y, paddle_0, paddle_1, paddlewidth, new_game,
    input  coll_L, coll_R, coll_T, coll_B, hit_zone, point_p1, point_p2,
           score_0, score_1, ball_reset, serving, game_over
  );

  modport slave (
    input  frame_tick, ball_x, ball_y, paddle_0, paddle_1, paddlewidth, new_game,
    output coll_L, coll_R, coll_T, coll_B, hit_zone, point_p1, point_p2,
           score_0, score_1, ball_reset, serving, game_over
  );
endinterface

// File: rtl/collision_engine.sv
// Frame-strobed wall/paddle contact detection with hit-zone reporting, scoring and
// a serve/play/game-over sequencer.
module collision_engine #(
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int WALL_MARGIN = 10,
  parameter int LEFT_X      = 40,
  parameter int RIGHT_X     = 592,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int PW_W        = 6,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  collision_engine_if.slave bus
);
  typedef enum logic [1:0] {S_PLAY, S_MISS, S_SERVE, S_OVER} state_t;

  localparam int YE    = Y_W + 1;
  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         latch_q, latch_d;   // {T, B, L, R}
  logic [3:0]         coll_q, coll_d;
  logic [1:0]         hz_q, hz_d;
  logic               pt1_q, pt1_d, pt2_q, pt2_d;
  logic               miss_left_q, miss_left_d;
  logic [SCORE_W-1:0] score0_q, score0_d, score1_q, score1_d, sc_new;

  logic [YE-1:0] by_e, pad_e, pw_e, ball_bot, pad_bot, center, off;
  logic [YE+1:0] off3, pw1, pw2;
  logic          in_t, in_b, in_l, in_r, overlap, miss;
  logic [1:0]    zone;
  logic [3:0]    cond;

  // Geometry is evaluated at one extra bit so the sums never wrap.
  always_comb begin
    by_e     = {1'b0, bus.ball_y};
    in_t     = by_e <= YE'(WALL_MARGIN);
    in_b     = !in_t && (by_e >= YE'(SCREEN_H - BALL_SIZE - WALL_MARGIN));
    in_l     = !in_t && !in_b && (bus.ball_x <= X_W'(LEFT_X));
    in_r     = !in_t && !in_b && !in_l && (bus.ball_x >= X_W'(RIGHT_X));
    pad_e    = in_l ? {1'b0, bus.paddle_0} : {1'b0, bus.paddle_1};
    pw_e     = YE'(bus.paddlewidth);
    ball_bot = by_e + YE'(BALL_SIZE);
    pad_bot  = pad_e + pw_e;
    overlap  = (ball_bot >= pad_e) && (by_e <= pad_bot);
    miss     = (in_l || in_r) && !overlap;
    cond     = {in_t, in_b, in_l && overlap, in_r && overlap};
    center   = by_e + YE'(BALL_SIZE / 2);
    off      = '0;
    if (center > pad_e) off = center - pad_e;
    if (off > pw_e) off = pw_e;
    off3     = {2'b00, off} + {1'b0, off, 1'b0};
    pw1      = {2'b00, pw_e};
    pw2      = {1'b0, pw_e, 1'b0};
    if (pw_e == '0)     zone = 2'd1;
    else if (off3 < pw1) zone = 2'd0;
    else if (off3 < pw2) zone = 2'd1;
    else                 zone = 2'd2;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_d     = latch_q;
    coll_d      = '0;
    hz_d        = hz_q;
    pt1_d       = 1'b0;
    pt2_d       = 1'b0;
    miss_left_d = miss_left_q;
    score0_d    = score0_q;
    score1_d    = score1_q;
    sc_new      = miss_left_q ? score1_q : score0_q;
    if (sc_new < SCORE_W'(WIN_SCORE)) sc_new = sc_new + SCORE_W'(1);
    if (bus.new_game) begin
      state_d  = S_SERVE;
      cnt_d    = '0;
      latch_d  = '0;
      score0_d = '0;
      score1_d = '0;
    end else begin
      case (state_q)
        S_PLAY: if (bus.frame_tick) begin
          coll_d  = cond & ~latch_q;
          latch_d = cond;
          if (coll_d[1] || coll_d[0]) hz_d = zone;
          if (miss) begin
            state_d     = S_MISS;
            miss_left_d = in_l;
          end
        end
        S_MISS: begin
          if (miss_left_q) begin
            pt2_d    = 1'b1;
            score1_d = sc_new;
          end else begin
            pt1_d    = 1'b1;
            score0_d = sc_new;
          end
          state_d = (sc_new == SCORE_W'(WIN_SCORE)) ? S_OVER : S_SERVE;
          cnt_d   = '0;
        end
        S_SERVE: if (bus.frame_tick) begin
          if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
            state_d = S_PLAY;
            cnt_d   = '0;
            latch_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_SERVE;
      cnt_q       <= '0;
      latch_q     <= '0;
      coll_q      <= '0;
      hz_q        <= '0;
      pt1_q       <= 1'b0;
      pt2_q       <= 1'b0;
      miss_left_q <= 1'b0;
      score0_q    <= '0;
      score1_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      latch_q     <= latch_d;
      coll_q      <= coll_d;
      hz_q        <= hz_d;
      pt1_q       <= pt1_d;
      pt2_q       <= pt2_d;
      miss_left_q <= miss_left_d;
      score0_q    <= score0_d;
      score1_q    <= score1_d;
    end
  end

  assign bus.coll_T     = coll_q[3];
  assign bus.coll_B     = coll_q[2];
  assign bus.coll_L     = coll_q[1];
  assign bus.coll_R     = coll_q[0];
  assign bus.hit_zone   = hz_q;
  assign bus.point_p1   = pt1_q;
  assign bus.point_p2   = pt2_q;
  assign bus.score_0    = score0_q;
  assign bus.score_1    = score1_q;
  assign bus.serving    = (state_q == S_SERVE);
  assign bus.game_over  = (state_q == S_OVER);
  assign bus.ball_reset = (state_q == S_SERVE) || (state_q == S_OVER);
endmodule

// File: tb/tb_collision_engine.sv
// Bench for collision_engine: directed table, hand sequences and random frames vs a frame-level model.
module tb_collision_engine;
  localparam int SD = 4;
  localparam int WIN = 9;
  localparam int M_SERVE = 0, M_PLAY = 1, M_OVER = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  collision_engine_if bus ();
  collision_engine #(.SERVE_DELAY(SD), .WIN_SCORE(WIN)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    int bx, by, p0, p1, pw;
    logic [3:0] coll;
    int hz;
    int pt;
  } vec_t;

  typedef struct {
    logic [3:0] coll;
    int hz, pt, s0, s1;
    bit serving, over;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int m_mode, m_cnt, m_s0, m_s1, m_hz;
  logic [3:0] m_prev;
  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SERVE; m_cnt = 0; m_s0 = 0; m_s1 = 0; m_hz = 0; m_prev = '0;
  endtask

  // One evaluation strobe as seen from the game rules.
  task automatic model_frame(input vec_t v, output exp_t e);
    bit t, b, l, r, hit;
    int pad, off;
    logic [3:0] c;
    e.coll = '0; e.pt = 0;
    if (m_mode == M_SERVE) begin
      m_cnt++;
      if (m_cnt == SD) begin m_mode = M_PLAY; m_prev = '0; end
    end else if (m_mode == M_PLAY) begin
      t = (v.by <= 10);
      b = !t && (v.by >= 480 - 8 - 10);
      l = !t && !b && (v.bx <= 40);
      r = !t && !b && !l && (v.bx >= 592);
      pad = l ? v.p0 : v.p1;
      hit = (v.by + 8 >= pad) && (v.by <= pad + v.pw);
      c = {t, b, l && hit, r && hit};
      e.coll = c & ~m_prev;
      m_prev = c;
      if (e.coll[1] || e.coll[0]) begin
        off = v.by + 4 - pad;
        if (off < 0) off = 0;
        if (off > v.pw) off = v.pw;
        if (v.pw == 0) m_hz = 1;
        else if (3 * off < v.pw) m_hz = 0;
        else if (3 * off < 2 * v.pw) m_hz = 1;
        else m_hz = 2;
      end
      if ((l || r) && !hit) begin
        if (l) begin e.pt = 2; if (m_s1 < WIN) m_s1++; end
        else   begin e.pt = 1; if (m_s0 < WIN) m_s0++; end
        m_mode = (m_s0 == WIN || m_s1 == WIN) ? M_OVER : M_SERVE;
        m_cnt = 0;
      end
    end
    e.hz = m_hz; e.s0 = m_s0; e.s1 = m_s1;
    e.serving = (m_mode == M_SERVE); e.over = (m_mode == M_OVER);
  endtask

  task automatic drive(input vec_t v);
    bus.ball_x = v.bx[9:0]; bus.ball_y = v.by[8:0];
    bus.paddle_0 = v.p0[8:0]; bus.paddle_1 = v.p1[8:0]; bus.paddlewidth = v.pw[5:0];
  endtask

  task automatic do_frame(input vec_t v, input bit use_tbl);
    exp_t e;
    model_frame(v, e);
    if (use_tbl) begin e.coll = v.coll; e.hz = v.hz; e.pt = v.pt; end
    drive(v);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    chk("coll_pulse", {bus.coll_T, bus.coll_B, bus.coll_L, bus.coll_R}, e.coll);
    chk("hit_zone", bus.hit_zone, e.hz);
    chk("point_early", {bus.point_p2, bus.point_p1}, 0);
    @(negedge clk);
    chk("coll_width", {bus.coll_T, bus.coll_B, bus.coll_L, bus.coll_R}, 0);
    chk("point_pulse", {bus.point_p2, bus.point_p1}, e.pt);
    chk("score_0", bus.score_0, e.s0);
    chk("score_1", bus.score_1, e.s1);
    chk("serving", bus.serving, e.serving);
    chk("game_over", bus.game_over, e.over);
    chk("ball_reset", bus.ball_reset, e.serving || e.over);
    bus.ball_x = 10'($urandom_range(0, 639));
    bus.ball_y = 9'($urandom_range(0, 471));
    @(negedge clk);
  endtask

  task automatic serve_frames(input int n);
    vec_t v = '{300, 200, 0, 0, 48, 4'b0, 0, 0};
    for (int i = 0; i < n; i++) do_frame(v, 1'b0);
  endtask

  task automatic do_new_game(input bit with_tick);
    bus.new_game = 1'b1; bus.frame_tick = with_tick;
    bus.ball_x = 10'd20; bus.ball_y = 9'd300;
    @(negedge clk);
    bus.new_game = 1'b0; bus.frame_tick = 1'b0;
    chk("ng_score_0", bus.score_0, 0);
    chk("ng_score_1", bus.score_1, 0);
    chk("ng_serving", bus.serving, 1);
    chk("ng_game_over", bus.game_over, 0);
    m_mode = M_SERVE; m_cnt = 0; m_s0 = 0; m_s1 = 0; m_prev = '0;
    @(negedge clk);
  endtask

  function automatic int clampy(input int y);
    if (y < 0) return 0;
    if (y > 471) return 471;
    return y;
  endfunction

  initial begin
    vec_t lmiss = '{20, 300, 50, 0, 20, 4'b0, 0, 0};
    vec_t rmiss = '{620, 300, 0, 50, 40, 4'b0, 0, 0};
    vec_t v;
    tbl[0]  = '{300, 5,   0,  0,   48, 4'b1000, 0, 0};
    tbl[1]  = '{300, 5,   0,  0,   48, 4'b0000, 0, 0};
    tbl[2]  = '{300, 5,   0,  0,   48, 4'b0000, 0, 0};
    tbl[3]  = '{300, 200, 0,  0,   48, 4'b0000, 0, 0};
    tbl[4]  = '{300, 5,   0,  0,   48, 4'b1000, 0, 0};
    tbl[5]  = '{40,  100, 96, 0,   48, 4'b0010, 0, 0};
    tbl[6]  = '{300, 100, 96, 0,   48, 4'b0000, 0, 0};
    tbl[7]  = '{40,  110, 96, 0,   48, 4'b0010, 1, 0};
    tbl[8]  = '{300, 100, 96, 0,   48, 4'b0000, 1, 0};
    tbl[9]  = '{40,  140, 96, 0,   48, 4'b0010, 2, 0};
    tbl[10] = '{300, 200, 96, 0,   48, 4'b0000, 2, 0};
    tbl[11] = '{600, 100, 0,  100, 0,  4'b0001, 1, 0};
    tbl[12] = '{300, 200, 0,  100, 0,  4'b0000, 1, 0};
    tbl[13] = '{30,  3,   0,  0,   48, 4'b1000, 1, 0};
    tbl[14] = '{300, 200, 0,  0,   48, 4'b0000, 1, 0};
    tbl[15] = '{300, 462, 0,  0,   48, 4'b0100, 1, 0};
    tbl[16] = '{300, 461, 0,  0,   48, 4'b0000, 1, 0};
    tbl[17] = '{592, 300, 0,  50,  40, 4'b0000, 1, 1};

    bus.frame_tick = 1'b0; bus.new_game = 1'b0;
    bus.ball_x = '0; bus.ball_y = '0; bus.paddle_0 = '0; bus.paddle_1 = '0; bus.paddlewidth = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_coll", {bus.coll_T, bus.coll_B, bus.coll_L, bus.coll_R}, 0);
    chk("rst_hit_zone", bus.hit_zone, 0);
    chk("rst_points", {bus.point_p2, bus.point_p1}, 0);
    chk("rst_scores", {bus.score_1, bus.score_0}, 0);
    chk("rst_serving", bus.serving, 1);
    chk("rst_ball_reset", bus.ball_reset, 1);
    chk("rst_game_over", bus.game_over, 0);
    reset_n = 1'b1;
    model_reset();

    serve_frames(SD);
    for (int i = 0; i < 18; i++) do_frame(tbl[i], 1'b1);

    // Drive player 2 to the winning score, then confirm OVER holds.
    while (m_s1 < WIN) begin
      serve_frames(SD);
      do_frame(lmiss, 1'b0);
    end
    chk("win_game_over", bus.game_over, 1);
    chk("win_score_1", bus.score_1, WIN);
    for (int i = 0; i < 3; i++) do_frame(lmiss, 1'b0);
    do_new_game(1'b1);

    // Reset in the middle of SERVE restarts the serve count and clears scores.
    serve_frames(SD);
    do_frame(rmiss, 1'b0);
    serve_frames(2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_score_0", bus.score_0, 0);
    chk("mid_rst_serving", bus.serving, 1);
    reset_n = 1'b1;
    model_reset();
    serve_frames(SD);

    // Reset landing on the MISS cycle suppresses the point pulse.
    drive(rmiss);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("miss_rst_point", {bus.point_p2, bus.point_p1}, 0);
    chk("miss_rst_score_0", bus.score_0, 0);
    chk("miss_rst_serving", bus.serving, 1);
    reset_n = 1'b1;
    model_reset();

    for (int n = 0; n < 500; n++) begin
      if ((m_mode == M_OVER && $urandom_range(0, 2) == 0) || $urandom_range(0, 40) == 0) begin
        do_new_game(1'($urandom_range(0, 1)));
      end else begin
        case ($urandom_range(0, 3))
          0: v.bx = $urandom_range(0, 639);
          1: v.bx = $urandom_range(0, 40);
          2: v.bx = $urandom_range(592, 639);
          default: v.bx = $urandom_range(41, 591);
        endcase
        case ($urandom_range(0, 3))
          0: v.by = $urandom_range(0, 10);
          1: v.by = $urandom_range(462, 471);
          default: v.by = $urandom_range(11, 461);
        endcase
        v.pw = $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) begin
          v.p0 = clampy(v.by + $urandom_range(0, 40) - 30);
          v.p1 = clampy(v.by + $urandom_range(0, 40) - 30);
        end else begin
          v.p0 = $urandom_range(0, 471);
          v.p1 = $urandom_range(0, 471);
        end
        v.coll = '0; v.hz = 0; v.pt = 0;
        do_frame(v, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
